// File: rtl/core_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_lsu_ctrl
// Brief    : Memory-stage load/store sequencer. Decodes size and alignment,
//            runs one single-beat req/ack bus access with byte-lane selects,
//            formats load data and reports abort conditions as error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module core_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  // Timeout counter sized to hold the terminal count itself.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Sequencer states.
  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_BUS  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;
  localparam logic [1:0] C_ERR  = 2'd3;

  // Error cause codes.
  localparam logic [1:0] C_CAUSE_ILLEGAL  = 2'b00;
  localparam logic [1:0] C_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] C_CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] C_CAUSE_TIMEOUT  = 2'b11;

  // funct3[1:0] access sizes.
  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;

  logic [1:0]    r_state;
  logic [CW-1:0] r_tmo;
  logic [2:0]    r_funct3;   // captured access type, drives load formatting
  logic [1:0]    r_off;      // captured byte offset within the word

  logic          r_done;
  logic          r_err;
  logic [1:0]    r_err_cause;
  logic [31:0]   r_rdata;
  logic          r_bus_cyc;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [3:0]    r_bus_sel;
  logic [31:0]   r_bus_wdata;

  logic          w_illegal;
  logic          w_misaligned;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdata;
  logic [7:0]    w_lane_byte;
  logic [15:0]   w_lane_half;
  logic [31:0]   w_load_fmt;
  logic          w_tmo_hit;

  // Funct3 legality: loads allow LB/LH/LW/LBU/LHU, stores only SB/SH/SW.
  always_comb begin
    w_illegal = 1'b1;
    if (i_we) begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
        default:                w_illegal = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end
  end

  // Alignment check; only meaningful once funct3 is known to be legal.
  always_comb begin
    w_misaligned = 1'b0;
    case (i_funct3[1:0])
      C_SZ_HALF: w_misaligned = i_addr[0];
      C_SZ_WORD: w_misaligned = (i_addr[1:0] != 2'b00);
      default:   w_misaligned = 1'b0;
    endcase
  end

  // Byte-lane selects, shared by loads and stores.
  always_comb begin
    w_sel = 4'b0000;
    case (i_funct3[1:0])
      C_SZ_BYTE: begin
        case (i_addr[1:0])
          2'b00:   w_sel = 4'b0001;
          2'b01:   w_sel = 4'b0010;
          2'b10:   w_sel = 4'b0100;
          default: w_sel = 4'b1000;
        endcase
      end
      C_SZ_HALF: w_sel = i_addr[1] ? 4'b1100 : 4'b0011;
      default:   w_sel = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes so the slave picks it up via sel.
  always_comb begin
    w_wdata = 32'h0000_0000;
    if (i_we) begin
      case (i_funct3[1:0])
        C_SZ_BYTE: w_wdata = {4{i_wdata[7:0]}};
        C_SZ_HALF: w_wdata = {2{i_wdata[15:0]}};
        default:   w_wdata = i_wdata;
      endcase
    end
  end

  // Select the addressed byte/half lane from the returned word.
  always_comb begin
    w_lane_byte = i_bus_rdata[7:0];
    case (r_off)
      2'b00:   w_lane_byte = i_bus_rdata[7:0];
      2'b01:   w_lane_byte = i_bus_rdata[15:8];
      2'b10:   w_lane_byte = i_bus_rdata[23:16];
      default: w_lane_byte = i_bus_rdata[31:24];
    endcase
    w_lane_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane according to the captured funct3.
  always_comb begin
    w_load_fmt = i_bus_rdata;
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_lane_byte[7]}}, w_lane_byte};
      3'b001:  w_load_fmt = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_load_fmt = {24'h00_0000, w_lane_byte};
      3'b101:  w_load_fmt = {16'h0000, w_lane_half};
      default: w_load_fmt = i_bus_rdata;
    endcase
  end

  assign w_tmo_hit = (r_tmo == C_TMO_LAST);

  // Main sequencer: decode in IDLE, run the bus access, emit one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= C_IDLE;
      r_tmo       <= '0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cause <= 2'b00;
      r_rdata     <= 32'h0000_0000;
      r_bus_cyc   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_sel   <= 4'b0000;
      r_bus_wdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        C_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (i_req) begin
            if (w_illegal) begin
              r_state     <= C_ERR;
              r_err       <= 1'b1;
              r_err_cause <= C_CAUSE_ILLEGAL;
            end else if (w_misaligned) begin
              r_state     <= C_ERR;
              r_err       <= 1'b1;
              r_err_cause <= C_CAUSE_MISALIGN;
            end else begin
              r_state     <= C_BUS;
              r_tmo       <= '0;
              r_funct3    <= i_funct3;
              r_off       <= i_addr[1:0];
              r_bus_cyc   <= 1'b1;
              r_bus_we    <= i_we;
              r_bus_addr  <= {i_addr[31:2], 2'b00};
              r_bus_sel   <= w_sel;
              r_bus_wdata <= w_wdata;
            end
          end
        end

        C_BUS: begin
          if (i_bus_ack) begin
            // Ack wins over a simultaneous err or terminal count.
            r_state     <= C_DONE;
            r_done      <= 1'b1;
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            if (!r_bus_we) begin
              r_rdata <= w_load_fmt;
            end
          end else if (i_bus_err || w_tmo_hit) begin
            r_state     <= C_ERR;
            r_err       <= 1'b1;
            r_err_cause <= i_bus_err ? C_CAUSE_BUSERR : C_CAUSE_TIMEOUT;
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_tmo       <= r_tmo + 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        C_DONE: begin
          r_done  <= 1'b0;
          r_state <= C_IDLE;
        end

        default: begin
          r_err   <= 1'b0;
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state == C_BUS) | ((r_state == C_IDLE) & i_req);
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_err_cause = r_err_cause;
  assign o_bus_cyc   = r_bus_cyc;
  assign o_bus_stb   = r_bus_cyc;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_sel   = r_bus_sel;
  assign o_bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: doc/core_lsu_ctrl.md
Name: core_lsu_ctrl

Overview:
Load/store sequencer for the core's memory stage. It accepts one load or store per request from the pipeline and checks size and alignment. It then drives a single-beat req/ack data bus with byte-lane selects and lane-replicated write data, and formats and sign- or zero-extends load data. It stalls the pipeline for the duration of each access and reports misaligned, illegal, bus-error and timeout conditions as a one-cycle error pulse.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS-state cycles without ack/err before the access is aborted; must be at least 1. The counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
i_clk  in  1  core clock; all state updates on its rising edge
i_reset  in  1  synchronous, active-high reset
i_req  in  1  pipeline memory request valid; sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_funct3  in  3  RV32 load/store funct3
i_addr  in  32  effective byte address (ALU result)
i_wdata  in  32  raw rs2 value for stores
o_busy  out  1  pipeline stall, combinational
o_done  out  1  one-cycle pulse: access completed successfully
o_rdata  out  32  formatted load result, valid while o_done=1
o_err  out  1  one-cycle pulse: access aborted
o_err_cause  out  2  00 illegal funct3, 01 misaligned, 10 bus error, 11 timeout; valid while o_err=1
o_bus_cyc  out  1  bus cycle active
o_bus_stb  out  1  bus strobe; always equals o_bus_cyc
o_bus_we  out  1  bus write enable
o_bus_addr  out  32  word address {addr[31:2],2'b00}
o_bus_sel  out  4  byte-lane selects
o_bus_wdata  out  32  lane-replicated write data
i_bus_ack  in  1  slave acknowledge
i_bus_err  in  1  slave error
i_bus_rdata  in  32  slave read data, valid with ack

Behaviour:
- States: IDLE, BUS, DONE, ERR. Reset takes the block to IDLE and forces every registered output to 0: bus outputs, o_done, o_err, o_err_cause, o_rdata and the timeout counter.
- Reset asserted during BUS: o_bus_cyc/o_bus_stb drop at that edge. No o_done or o_err is produced for the aborted access.
- o_busy = (state==BUS) | (state==IDLE & i_req). o_busy is 0 in DONE and ERR, so the pipeline advances in the cycle o_done or o_err is high.
- IDLE with i_req=1, validity decode:
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 → ERR, cause 00.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) → ERR, cause 01.
  - Illegal funct3 takes priority over misaligned.
  - An access that goes to ERR from IDLE produces no bus activity.
- Legal request → BUS. All bus outputs are registered at the same edge, so cyc/stb are high from the cycle after i_req is sampled. Address, size and byte offset are captured internally, so the pipeline inputs need not stay stable.
- Byte-lane selects (identical for loads and stores):
  - Byte: one-hot 0001/0010/0100/1000 by addr[1:0].
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: 1111.
- Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata. For loads o_bus_wdata=0 and o_bus_we=0.
- In BUS:
  - i_bus_ack=1 → DONE. cyc/stb deassert at that edge.
  - For a load, o_rdata is registered from i_bus_rdata at that edge: the byte or half lane is selected by the captured offset and sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - For a store, o_rdata holds its previous value.
- In BUS, i_bus_err=1 without ack → ERR, cause 10. If ack and err are asserted in the same cycle, ack wins.
- Timeout:
  - The counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES → ERR, cause 11, and cyc/stb deassert.
  - Ack in the same cycle as the terminal count wins.
- DONE and ERR last exactly one cycle, then return to IDLE unconditionally. i_req is ignored in both states.
- Minimum latency with a zero-wait slave: i_req sampled at cycle 0, cyc high at cycle 1 with ack, o_done=1 at cycle 2. The next request can be sampled at cycle 3.
- o_done and o_err are never high together.
- o_err_cause holds its last value outside an o_err pulse.
- o_rdata holds its value until the next successful load.

Test Plan:
- LB at addr 0x103, bus rdata 0x80FF_1234, ack on first BUS cycle → o_bus_sel=1000, o_bus_addr=0x100, o_done at cycle 2, o_rdata=0xFFFF_FF80. Repeat as LBU → o_rdata=0x0000_0080.
- SH at addr 0x202, rs2=0xDEAD_BEEF, ack after 3 wait cycles → o_bus_we=1, sel=1100, wdata=0xBEEF_BEEF, o_busy high for 5 cycles, then o_done pulse.
- LW at addr 0x006 → o_err with cause 01 the cycle after the request, o_bus_cyc never asserted. Funct3 011 at any address → cause 00.
- TIMEOUT_CYCLES=4, slave never responds → cyc high for exactly 4 cycles, then o_err with cause 11. Ack and err together → o_done, no o_err.
- i_reset asserted during a BUS wait → cyc/stb/we/sel low after that edge, no o_done/o_err, next request accepted normally.
- Back-to-back LW(0x10) then SW(0x14), each with zero-wait ack → two o_done pulses 3 cycles apart and correct sel/we per access.
